xor_logic: RTL and testbench

Registered bitwise-XOR cipher stage for one-time-pad encoding and decoding. Each accepted word is XORed with a pad word, supplied either per-transaction on `b` or from an internal key register. Because XOR is an involution, the same block encodes plaintext and decodes ciphertext. It sits between a word source (message or ciphertext) and a word sink, with a one-cycle valid pipeline.

---
 rtl/xor_logic.sv | 46 ++++
 tb/tb_xor_logic.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/xor_logic.sv
// xor_logic: registered one-time-pad XOR stage with an optional stored key and a saturating word counter.
module xor_logic #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             key_load,
    input  logic             use_key,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic [CNT_W-1:0] word_count
);
    logic [WIDTH-1:0] c_q, c_d, key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    // The pad reads key_q, so a same-edge load and use sees the previous key.
    always_comb begin
        c_d     = in_valid ? a ^ (use_key ? key_q : b) : c_q;
        valid_d = in_valid;
        key_d   = key_load ? b : key_q;
        cnt_d   = (in_valid && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            valid_q <= 1'b0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            c_q     <= c_d;
            valid_q <= valid_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    assign c          = c_q;
    assign out_valid  = valid_q;
    assign word_count = cnt_q;
endmodule

// File: tb/tb_xor_logic.sv
// tb_xor_logic: directed and randomized checks of xor_logic against a behavioural pad/counter model.
module tb_xor_logic;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, key_load, use_key;
    logic [31:0] a, b, c, c4;
    logic        out_valid, out_valid4;
    logic [15:0] word_count;
    logic [3:0]  word_count4;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_key, m_c;
    logic        m_v;
    int          m_n;

    always #5 clk = ~clk;

    xor_logic #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .key_load(key_load), .use_key(use_key), .c(c), .out_valid(out_valid),
        .word_count(word_count)
    );

    xor_logic #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .key_load(key_load), .use_key(use_key), .c(c4), .out_valid(out_valid4),
        .word_count(word_count4)
    );

    function automatic int sat(input int n, input int mx);
        return n > mx ? mx : n;
    endfunction

    task automatic model_reset();
        m_key = 0; m_c = 0; m_v = 0; m_n = 0;
    endtask

    task automatic cyc(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic kl, input logic uk);
        in_valid = iv; a = ia; b = ib; key_load = kl; use_key = uk;
        @(posedge clk);
        if (iv) begin
            m_c = ia ^ (uk ? m_key : ib);
            m_n++;
        end
        m_v = iv;
        if (kl) m_key = ib;
        #1;
        in_valid = 0; key_load = 0;
    endtask

    task automatic test_reset();
        checks++;
        if (c !== 32'h0 || out_valid !== 1'b0 || word_count !== 16'h0) begin
            errors++;
            $display("FAIL reset: c=%h v=%b n=%0d required c=0 v=0 n=0", c, out_valid, word_count);
        end
    endtask

    task automatic test_encode_decode();
        cyc(1, 32'h74657374, 32'h8A164DB8, 0, 0);
        checks++;
        if (c !== 32'hFE733ECC || out_valid !== 1'b1 || word_count !== 16'd1) begin
            errors++;
            $display("FAIL encode: c=%h v=%b n=%0d required c=fe733ecc v=1 n=1", c, out_valid, word_count);
        end
        cyc(1, 32'hFE733ECC, 32'h8A164DB8, 0, 0);
        checks++;
        if (c !== 32'h74657374 || out_valid !== 1'b1 || word_count !== 16'd2) begin
            errors++;
            $display("FAIL decode: c=%h v=%b n=%0d required c=74657374 v=1 n=2", c, out_valid, word_count);
        end
    endtask

    task automatic test_stored_key();
        cyc(0, 32'h0, 32'h8A164DB8, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL key_load_idle: v=%b required 0", out_valid);
        end
        cyc(1, 32'h74657374, 32'hFFFFFFFF, 0, 1);
        checks++;
        if (c !== 32'hFE733ECC) begin
            errors++;
            $display("FAIL stored_key: c=%h required fe733ecc", c);
        end
        cyc(1, 32'h74657374, 32'h12345678, 1, 1);
        checks++;
        if (c !== 32'hFE733ECC) begin
            errors++;
            $display("FAIL load_and_use_old_key: c=%h required fe733ecc", c);
        end
        cyc(1, 32'h74657374, 32'h0, 0, 1);
        checks++;
        if (c !== 32'h6651250C) begin
            errors++;
            $display("FAIL new_key_next_edge: c=%h required 6651250c", c);
        end
    endtask

    task automatic test_identities();
        cyc(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        checks++;
        if (c !== 32'h0) begin
            errors++;
            $display("FAIL ones_xor_ones: c=%h required 00000000", c);
        end
        cyc(1, 32'hA5A5A5A5, 32'h0, 0, 0);
        checks++;
        if (c !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL xor_zero: c=%h required a5a5a5a5", c);
        end
        cyc(0, 32'h12345678, 32'h9ABCDEF0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || c !== 32'hA5A5A5A5 || word_count !== 16'(m_n)) begin
            errors++;
            $display("FAIL hold: c=%h v=%b n=%0d required c=a5a5a5a5 v=0 n=%0d", c, out_valid, word_count, m_n);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            cyc(1, $urandom, $urandom, 0, 0);
            checks++;
            if (out_valid !== 1'b1 || c !== m_c || word_count !== 16'(m_n)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: c=%h v=%b n=%0d required c=%h v=1 n=%0d", i, c, out_valid, word_count, m_c, m_n);
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(1, 32'hCAFEF00D, 32'h0F0F0F0F, 1, 0);
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (c !== 32'h0 || out_valid !== 1'b0 || word_count !== 16'h0 || word_count4 !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: c=%h v=%b n=%0d n4=%0d required all 0", c, out_valid, word_count, word_count4);
        end
        #3 rst_n = 1;
        cyc(1, 32'hDEADBEEF, 32'h55555555, 0, 1);
        checks++;
        if (c !== 32'hDEADBEEF || out_valid !== 1'b1 || word_count !== 16'd1) begin
            errors++;
            $display("FAIL key_zero_after_reset: c=%h v=%b n=%0d required c=deadbeef v=1 n=1", c, out_valid, word_count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            cyc(1, $urandom, $urandom, 0, 0);
            checks++;
            if (word_count4 !== 4'(sat(m_n, 15)) || word_count !== 16'(m_n)) begin
                errors++;
                $display("FAIL saturation[%0d]: n4=%0d n=%0d required n4=%0d n=%0d", i, word_count4, word_count, sat(m_n, 15), m_n);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            checks++;
            if (c !== m_c || out_valid !== m_v || word_count !== 16'(sat(m_n, 65535))
                || word_count4 !== 4'(sat(m_n, 15)) || c4 !== m_c) begin
                errors++;
                $display("FAIL random[%0d]: c=%h v=%b n=%0d n4=%0d required c=%h v=%b n=%0d n4=%0d",
                         i, c, out_valid, word_count, word_count4, m_c, m_v, m_n, sat(m_n, 15));
            end
        end
    endtask

    initial begin
        rst_n = 0; in_valid = 0; key_load = 0; use_key = 0; a = 0; b = 0;
        model_reset();
        #12;
        test_reset();
        rst_n = 1;
        test_encode_decode();
        test_stored_key();
        test_identities();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
